// File: rtl/cic_integrator_chain.sv
`default_nettype none
// ============================================================================
//  Module      : cic_integrator_chain
//  Description : ORDER-stage cascaded CIC integrator with built-in decimation.
//                Each stage works at an effective width W = IDW + ORDER*os_sel
//                and either wraps or saturates on overflow. Every R = 2^os_sel
//                accepted samples the last stage is published on data_out
//                with a one-cycle out_valid strobe. os_sel 0 (or any value
//                beyond MAX_OSBITS) bypasses the integrators.
//  Ports       : clk       - rising-edge clock
//                reset_n   - asynchronous active-low reset
//                os_sel    - log2 of decimation ratio (0/7 = bypass)
//                sat_en    - 1 = saturate on stage overflow, 0 = wrap
//                in_valid  - data_in accepted on this edge
//                data_in   - two's complement input sample (IDW bits)
//                ovf_clr   - synchronous clear of ovf_flag
//                out_valid - one-cycle pulse, data_out just updated
//                data_out  - decimated output, sign-extended to ODW bits
//                ovf_flag  - sticky per-stage overflow flags
//  Revision    : 1.0 - initial release
// ============================================================================
module cic_integrator_chain #(
  parameter int IDW        = 16,
  parameter int ORDER      = 3,
  parameter int MAX_OSBITS = 6,
  parameter int ODW        = 34
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       os_sel,
  input  logic             sat_en,
  input  logic             in_valid,
  input  logic [IDW-1:0]   data_in,
  input  logic             ovf_clr,
  output logic             out_valid,
  output logic [ODW-1:0]   data_out,
  output logic [ORDER-1:0] ovf_flag
);

  generate
    if (ODW < IDW + ORDER * MAX_OSBITS) begin : g_odw_check
      $error("cic_integrator_chain: ODW must be >= IDW + ORDER*MAX_OSBITS");
    end
    if (ORDER < 1 || ORDER > 5) begin : g_order_check
      $error("cic_integrator_chain: ORDER must lie in 1..5");
    end
  endgenerate

  logic [2:0]                os_sel_q;
  logic [MAX_OSBITS-1:0]     cnt;
  logic [ORDER-1:0][ODW-1:0] acc;
  logic [ORDER-1:0][ODW-1:0] acc_next;
  logic [ORDER-1:0]          stage_ovf;
  logic                      bypass;
  logic                      mode_change;
  logic                      frame_end;
  logic [MAX_OSBITS-1:0]     cnt_last;
  logic [ODW-1:0]            data_sext;
  int                        width;

  // One integrator add: the sum is formed one bit wider than the accumulator
  // so the true result is always representable, then checked against the
  // signed W-bit range. Returns {overflow, new accumulator value}.
  function automatic logic [ODW:0] stage_add(input logic [ODW-1:0] acc_v,
                                             input logic [ODW-1:0] add_v,
                                             input int             w,
                                             input logic           sat);
    logic signed [ODW:0] sum;
    logic signed [ODW:0] one;
    logic signed [ODW:0] hi;
    logic signed [ODW:0] lo;
    logic signed [ODW:0] wrapped;
    logic signed [ODW:0] res;
    logic                ovf;
    int                  sh;
    sum     = $signed({acc_v[ODW-1], acc_v}) + $signed({add_v[ODW-1], add_v});
    one     = {{ODW{1'b0}}, 1'b1};
    hi      = (one <<< (w - 1)) - one;
    lo      = -(one <<< (w - 1));
    sh      = ODW + 1 - w;
    // Shift the W live bits to the top, then arithmetic-shift back down:
    // keeps the low W bits and sign-extends them in one step.
    wrapped = (sum <<< sh) >>> sh;
    ovf     = 1'b1;
    if (sum > hi) begin
      res = sat ? hi : wrapped;
    end else if (sum < lo) begin
      res = sat ? lo : wrapped;
    end else begin
      res = sum;
      ovf = 1'b0;
    end
    return {ovf, res[ODW-1:0]};
  endfunction

  always_comb begin
    bypass      = (os_sel_q == 3'd0) || (int'(os_sel_q) > MAX_OSBITS);
    mode_change = (os_sel != os_sel_q);
    width       = bypass ? IDW : IDW + ORDER * int'(os_sel_q);
    // R-1 as a mask of os_sel_q ones; the frame ends when cnt reaches it.
    cnt_last    = ~({MAX_OSBITS{1'b1}} << os_sel_q);
    frame_end   = (cnt == cnt_last);
    data_sext   = {{(ODW-IDW){data_in[IDW-1]}}, data_in};
  end

  // All stages read pre-edge accumulator values, so an input needs
  // ORDER-1 further accepted samples to reach the last stage.
  always_comb begin
    acc_next  = acc;
    stage_ovf = '0;
    {stage_ovf[0], acc_next[0]} = stage_add(acc[0], data_sext, width, sat_en);
    for (int i = 1; i < ORDER; i++) begin
      {stage_ovf[i], acc_next[i]} = stage_add(acc[i], acc[i-1], width, sat_en);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      os_sel_q  <= 3'd0;
      cnt       <= '0;
      acc       <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      ovf_flag  <= '0;
    end else begin
      // A fresh overflow on the same edge as ovf_clr leaves the flag set.
      ovf_flag  <= (ovf_clr ? '0 : ovf_flag) |
                   ((in_valid && !bypass && !mode_change) ? stage_ovf : '0);
      out_valid <= 1'b0;
      if (mode_change) begin
        // Flush: restart framing cleanly in the new ratio, dropping this
        // edge's sample; overflow history is kept.
        os_sel_q <= os_sel;
        cnt      <= '0;
        acc      <= '0;
        data_out <= '0;
      end else if (in_valid) begin
        if (bypass) begin
          cnt       <= '0;
          acc       <= '0;
          data_out  <= data_sext;
          out_valid <= 1'b1;
        end else begin
          acc <= acc_next;
          if (frame_end) begin
            cnt       <= '0;
            data_out  <= acc_next[ORDER-1];
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + MAX_OSBITS'(1);
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cic_integrator_chain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cic_integrator_chain
//  Description : Self-checking bench for cic_integrator_chain. A behavioural
//                integer model predicts every decimated output; predictions
//                are queued when stimulus is applied and compared when the
//                DUT raises out_valid. Fixed reference values from the
//                impulse, saturation, wrap and mode-change scenarios are
//                checked alongside.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cic_integrator_chain;

  logic        clk      = 1'b0;
  logic        reset_n  = 1'b0;
  logic [2:0]  os_sel   = 3'd0;
  logic        sat_en   = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] data_in  = '0;
  logic        ovf_clr  = 1'b0;
  logic        out_valid;
  logic [33:0] data_out;
  logic [2:0]  ovf_flag;

  int          total  = 0;
  int          passed = 0;
  logic [33:0] exp_q[$];

  // Reference model state
  longint      m_acc[3];
  int          m_cnt;
  logic [2:0]  m_osq;
  logic [2:0]  m_ovf;

  cic_integrator_chain #(
    .IDW        (16),
    .ORDER      (3),
    .MAX_OSBITS (6),
    .ODW        (34)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .os_sel    (os_sel),
    .sat_en    (sat_en),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .ovf_clr   (ovf_clr),
    .out_valid (out_valid),
    .data_out  (data_out),
    .ovf_flag  (ovf_flag)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_acc = '{0, 0, 0};
    m_cnt = 0;
    m_osq = 3'd0;
    m_ovf = 3'd0;
    exp_q.delete();
  endfunction

  // Applies one clock edge to the model using the current input values.
  function automatic void model_edge();
    longint      n[3];
    longint      m;
    longint      hi;
    longint      lo;
    int          w;
    logic [33:0] e;
    if (os_sel != m_osq) begin
      m_acc = '{0, 0, 0};
      m_cnt = 0;
      m_osq = os_sel;
      if (ovf_clr) m_ovf = 3'd0;
      return;
    end
    if (ovf_clr) m_ovf = 3'd0;
    if (!in_valid) return;
    if (os_sel == 3'd0 || os_sel == 3'd7) begin
      e = {{18{data_in[15]}}, data_in};
      exp_q.push_back(e);
      return;
    end
    w  = 16 + 3 * int'(os_sel);
    m  = longint'(1) <<< w;
    hi = m / 2 - 1;
    lo = -(m / 2);
    n[0] = m_acc[0] + longint'($signed(data_in));
    n[1] = m_acc[1] + m_acc[0];
    n[2] = m_acc[2] + m_acc[1];
    for (int i = 0; i < 3; i++) begin
      if (n[i] > hi || n[i] < lo) begin
        m_ovf[i] = 1'b1;
        if (sat_en) begin
          n[i] = (n[i] > hi) ? hi : lo;
        end else begin
          n[i] = (n[i] - lo) % m;
          if (n[i] < 0) n[i] = n[i] + m;
          n[i] = n[i] + lo;
        end
      end
    end
    m_acc = n;
    if (m_cnt == (1 << os_sel) - 1) begin
      e = 34'(n[2]);
      exp_q.push_back(e);
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endfunction

  // Drive one cycle of stimulus; returns #1 after the active edge.
  task automatic step(input logic v, input int d);
    in_valid = v;
    data_in  = 16'(d);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
    total++; if (data_out !== 34'd0) $display("FAIL reset_data_out: got %0d expected 0", $signed(data_out)); else passed++;
    total++; if (ovf_flag !== 3'd0) $display("FAIL reset_ovf_flag: got %b expected 000", ovf_flag); else passed++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_impulse();
    logic [33:0] golden[4] = '{34'd0, 34'd4, 34'd20, 34'd56};
    logic [33:0] ev;
    int          pulse = 0;
    os_sel = 3'd1;
    sat_en = 1'b0;
    step(1'b0, 0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1);
      total++;
      if (out_valid !== (k % 2 == 0)) $display("FAIL impulse_strobe: sample %0d out_valid=%b expected %b", k, out_valid, (k % 2 == 0));
      else passed++;
      if (out_valid) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL impulse_data: out_valid=1 but no output expected");
        else begin
          ev = exp_q.pop_front();
          if (data_out !== ev) $display("FAIL impulse_data: got %0d expected %0d", $signed(data_out), $signed(ev));
          else passed++;
        end
        if (pulse < 4) begin
          total++;
          if (data_out !== golden[pulse]) $display("FAIL impulse_golden: pulse %0d got %0d expected %0d", pulse, $signed(data_out), golden[pulse]);
          else passed++;
        end
        pulse++;
      end
    end
    total++; if (exp_q.size() != 0) $display("FAIL impulse_missing: %0d outputs never appeared, expected 0", exp_q.size()); else passed++;
    exp_q.delete();
  endtask

  // Nine samples of constant d at W=19: checks acc[0] after 8 and 9 samples,
  // the stage-0 flag, its persistence and its clear.
  task automatic test_bound(input logic sat, input int d, input longint exp8, input longint exp9);
    logic [33:0] ev;
    os_sel = 3'd0; step(1'b0, 0);
    os_sel = 3'd1; step(1'b0, 0);
    ovf_clr = 1'b1; step(1'b0, 0);
    ovf_clr = 1'b0;
    sat_en  = sat;
    for (int k = 1; k <= 9; k++) begin
      step(1'b1, d);
      if (out_valid) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL bound_data: out_valid=1 but no output expected");
        else begin
          ev = exp_q.pop_front();
          if (data_out !== ev) $display("FAIL bound_data: sat=%0b got %0d expected %0d", sat, $signed(data_out), $signed(ev));
          else passed++;
        end
      end
      if (k == 8) begin
        total++; if (dut.acc[0] !== 34'(exp8)) $display("FAIL bound_acc8: sat=%0b got %0d expected %0d", sat, $signed(dut.acc[0]), exp8); else passed++;
        total++; if (ovf_flag[0] !== 1'b0) $display("FAIL bound_flag8: sat=%0b got %b expected 0", sat, ovf_flag[0]); else passed++;
      end
      if (k == 9) begin
        total++; if (dut.acc[0] !== 34'(exp9)) $display("FAIL bound_acc9: sat=%0b got %0d expected %0d", sat, $signed(dut.acc[0]), exp9); else passed++;
        total++; if (ovf_flag[0] !== 1'b1) $display("FAIL bound_flag9: sat=%0b got %b expected 1", sat, ovf_flag[0]); else passed++;
        total++; if (ovf_flag !== m_ovf) $display("FAIL bound_flags: sat=%0b got %b expected %b", sat, ovf_flag, m_ovf); else passed++;
      end
    end
    step(1'b0, 0);
    step(1'b0, 0);
    total++; if (ovf_flag[0] !== 1'b1) $display("FAIL bound_sticky: got %b expected 1", ovf_flag[0]); else passed++;
    ovf_clr = 1'b1; step(1'b0, 0); ovf_clr = 1'b0;
    total++; if (ovf_flag !== 3'd0) $display("FAIL bound_clear: got %b expected 000", ovf_flag); else passed++;
    total++; if (exp_q.size() != 0) $display("FAIL bound_missing: %0d outputs never appeared, expected 0", exp_q.size()); else passed++;
    exp_q.delete();
  endtask

  task automatic test_bypass();
    logic        v_tab[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int          d_tab[5] = '{-5, 0, 0, 7, 0};
    logic [33:0] ev;
    os_sel = 3'd0;
    step(1'b0, 0);
    for (int k = 0; k < 5; k++) begin
      step(v_tab[k], d_tab[k]);
      total++;
      if (out_valid !== v_tab[k]) $display("FAIL bypass_strobe: step %0d out_valid=%b expected %b", k, out_valid, v_tab[k]);
      else passed++;
      if (out_valid) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL bypass_data: out_valid=1 but no output expected");
        else begin
          ev = exp_q.pop_front();
          if (data_out !== ev) $display("FAIL bypass_data: got %0d expected %0d", $signed(data_out), $signed(ev));
          else passed++;
        end
      end
      if (k == 0) begin
        total++; if (data_out !== 34'h3_FFFF_FFFB) $display("FAIL bypass_neg: got %h expected 3fffffffb", data_out); else passed++;
      end
      if (k == 3) begin
        total++; if (data_out !== 34'd7) $display("FAIL bypass_pos: got %0d expected 7", $signed(data_out)); else passed++;
      end
    end
    total++; if (dut.acc[0] !== 34'd0) $display("FAIL bypass_acc0: got %0d expected 0", $signed(dut.acc[0])); else passed++;
    total++; if (dut.acc[2] !== 34'd0) $display("FAIL bypass_acc2: got %0d expected 0", $signed(dut.acc[2])); else passed++;
    total++; if (exp_q.size() != 0) $display("FAIL bypass_missing: %0d outputs never appeared, expected 0", exp_q.size()); else passed++;
    exp_q.delete();
  endtask

  task automatic test_mode_change();
    logic [33:0] ev;
    sat_en = 1'b0;
    os_sel = 3'd2;
    step(1'b0, 0);
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 1);
      if (out_valid) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL mode_data: out_valid=1 but no output expected");
        else begin
          ev = exp_q.pop_front();
          if (data_out !== ev) $display("FAIL mode_data: got %0d expected %0d", $signed(data_out), $signed(ev));
          else passed++;
        end
      end
    end
    total++; if (data_out !== 34'd4) $display("FAIL mode_pre: got %0d expected 4", $signed(data_out)); else passed++;
    os_sel = 3'd3;
    step(1'b1, 1);
    total++; if (out_valid !== 1'b0) $display("FAIL mode_flush_strobe: got %b expected 0", out_valid); else passed++;
    total++; if (data_out !== 34'd0) $display("FAIL mode_flush_data: got %0d expected 0", $signed(data_out)); else passed++;
    total++; if (dut.acc[0] !== 34'd0) $display("FAIL mode_flush_acc: got %0d expected 0", $signed(dut.acc[0])); else passed++;
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1);
      total++;
      if (out_valid !== (k == 8)) $display("FAIL mode_strobe: sample %0d out_valid=%b expected %b", k, out_valid, (k == 8));
      else passed++;
      if (out_valid) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL mode_data: out_valid=1 but no output expected");
        else begin
          ev = exp_q.pop_front();
          if (data_out !== ev) $display("FAIL mode_data: got %0d expected %0d", $signed(data_out), $signed(ev));
          else passed++;
        end
        total++; if (data_out !== 34'd56) $display("FAIL mode_golden: got %0d expected 56", $signed(data_out)); else passed++;
      end
    end
    total++; if (exp_q.size() != 0) $display("FAIL mode_missing: %0d outputs never appeared, expected 0", exp_q.size()); else passed++;
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    logic [33:0] ev;
    for (int k = 0; k < 3; k++) step(1'b1, 2);
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (data_out !== 34'd0) $display("FAIL rst_mid_data: got %0d expected 0", $signed(data_out)); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_mid_strobe: got %b expected 0", out_valid); else passed++;
    total++; if (ovf_flag !== 3'd0) $display("FAIL rst_mid_flags: got %b expected 000", ovf_flag); else passed++;
    total++; if (dut.acc[0] !== 34'd0) $display("FAIL rst_mid_acc: got %0d expected 0", $signed(dut.acc[0])); else passed++;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 5);
    total++; if (dut.acc[0] !== 34'd0) $display("FAIL rst_release_flush: acc0 got %0d expected 0", $signed(dut.acc[0])); else passed++;
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1);
      if (out_valid) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL rst_release_data: out_valid=1 but no output expected");
        else begin
          ev = exp_q.pop_front();
          if (data_out !== ev) $display("FAIL rst_release_data: got %0d expected %0d", $signed(data_out), $signed(ev));
          else passed++;
        end
      end
    end
    total++; if (exp_q.size() != 0) $display("FAIL rst_release_missing: %0d outputs never appeared, expected 0", exp_q.size()); else passed++;
    exp_q.delete();
  endtask

  task automatic test_ovf_collision();
    logic [33:0] ev;
    os_sel = 3'd0; step(1'b0, 0);
    os_sel = 3'd1; step(1'b0, 0);
    ovf_clr = 1'b1; step(1'b0, 0);
    ovf_clr = 1'b0;
    sat_en  = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      if (k == 9) ovf_clr = 1'b1;
      step(1'b1, 32767);
      if (out_valid) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL collide_data: out_valid=1 but no output expected");
        else begin
          ev = exp_q.pop_front();
          if (data_out !== ev) $display("FAIL collide_data: got %0d expected %0d", $signed(data_out), $signed(ev));
          else passed++;
        end
      end
    end
    ovf_clr = 1'b0;
    total++; if (ovf_flag[0] !== 1'b1) $display("FAIL collide_flag0: got %b expected 1", ovf_flag[0]); else passed++;
    total++; if (ovf_flag !== m_ovf) $display("FAIL collide_flags: got %b expected %b", ovf_flag, m_ovf); else passed++;
    ovf_clr = 1'b1; step(1'b0, 0); ovf_clr = 1'b0;
    total++; if (ovf_flag !== 3'd0) $display("FAIL collide_clear: got %b expected 000", ovf_flag); else passed++;
    exp_q.delete();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_impulse();
    test_bound(1'b1,  32767,  262136,  262143);
    test_bound(1'b0,  32767,  262136, -229385);
    test_bound(1'b1, -32768, -262144, -262144);
    test_bound(1'b0, -32768, -262144,  229376);
    test_bypass();
    test_mode_change();
    test_reset_mid_frame();
    test_ovf_collision();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cic_integrator_chain.md
# cic_integrator_chain

Parametrised N-stage CIC integrator section with built-in decimation control, the successor to the single-stage integrator in the CIC decimator datapath. Cascades `ORDER` integrators on one clock, with range sized from the selected oversampling ratio, and wrap or saturate arithmetic per stage. It counts accepted input samples and emits one decimated sample every R inputs to the comb section. The separate divided clock used previously is replaced by a `out_valid` strobe.

## Interface
- `IDW`, 16: input data width, two's complement.
- `ORDER`, 3: number of cascaded integrator stages, 1..5.
- `MAX_OSBITS`, 6: largest log2(R) supported.
- `ODW`, 34: accumulator/output width; must satisfy ODW >= IDW + ORDER*MAX_OSBITS (elaboration error otherwise).

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `os_sel` in 3: R = 2^os_sel for 1..6. 0 or 7 selects bypass.
- `sat_en` in 1: 1 = saturate on stage overflow, 0 = modular wrap.
- `in_valid` in 1: data_in is accepted on this edge.
- `data_in` in IDW: input sample.
- `ovf_clr` in 1: synchronous clear of `ovf_flag`.
- `out_valid` out 1: one-cycle pulse, data_out updated.
- `data_out` out ODW: decimated integrator output, sign-extended.
- `ovf_flag` out ORDER: sticky per-stage overflow flags.

## Operation
- Effective width: W = IDW + ORDER*os_sel. Every accumulator holds a W-bit signed value sign-extended to ODW.
- Stage update on each accepted sample (`in_valid`=1), all stages in the same edge, using pre-edge values:
  - acc[0] += sext(data_in)
  - acc[i] += acc[i-1], for i >= 1
- No stage updates when `in_valid`=0.
- Sums are formed in ODW+1 bits. Overflow occurs when the result lies outside [-2^(W-1), 2^(W-1)-1].
- On overflow:
  - `sat_en`=0: keep the low W bits, sign-extend.
  - `sat_en`=1: clamp to the violated bound.
  - Both modes: set `ovf_flag[i]`.
- `ovf_flag` clears only on `ovf_clr` or reset. If `ovf_clr` and a new overflow occur in the same edge, set wins.
- Decimation counter `cnt` (MAX_OSBITS bits) advances on each accepted sample and wraps at R-1.
- On an accepted sample with `cnt`==R-1:
  - `data_out` loads the new acc[ORDER-1] value in the same edge.
  - `out_valid`=1 for the following cycle.
- Bypass (os_sel 0 or 7):
  - Accumulators and `cnt` are held at 0.
  - Each accepted sample loads sext(data_in) into `data_out` and pulses `out_valid`.
  - No overflow is possible.
- Mode change: `os_sel` is registered as `os_sel_q`. On any edge where `os_sel` != `os_sel_q`:
  - Accumulators, `cnt`, `data_out` and `out_valid` go to 0.
  - That edge's sample is dropped.
  - `os_sel_q` is updated.
  - `ovf_flag` is preserved.
- `sat_en` is not registered. It takes effect on the next update.

## Timing
- Reset (`reset_n`=0, asynchronous): all accumulators, `cnt`, `os_sel_q` (to 0), `data_out`, `out_valid` and `ovf_flag` go to 0. State is cleared mid-frame, with no partial output.
- Reset release: the first edge with `reset_n`=1 acts normally. If `os_sel` != 0 at release, that first edge is a flush (mode-change) edge.
- Throughput: one sample per cycle, no back-pressure.
- Latency: `out_valid` is high in the cycle after the edge that accepted the R-th sample of a frame.
- Pipeline skew: because stages use pre-edge values, an input reaches acc[ORDER-1] ORDER-1 accepted samples later. The comb section absorbs this.
- With `in_valid` held high and R=2, `out_valid` toggles every other cycle. Gaps in `in_valid` stretch frames but never drop samples.

## Test plan
- Impulse response, ORDER=3, os_sel=1, `in_valid` continuous, data_in=1 constant: `data_out` = 0, 4, 20, 56 on successive `out_valid` pulses; `out_valid` every 2nd cycle.
- Saturation, os_sel=1, W=19, `sat_en`=1, data_in=32767: acc[0] = 262136 after 8 samples; 9th sample gives 262143, `ovf_flag[0]`=1; flag persists until `ovf_clr`.
- Wrap, same stimulus, `sat_en`=0: 9th sample gives acc[0] = -229385, `ovf_flag[0]`=1; negative input -32768 checks the lower bound symmetrically.
- Bypass, os_sel=0, data_in = -5, 7, with gaps in `in_valid`: `data_out` = sext(-5) then 7; one `out_valid` per accepted sample; accumulators stay 0.
- Mode change mid-frame, os_sel 2→3 after 2 samples: flush edge zeroes state and drops that sample; next `out_valid` arrives after 8 further samples.
- Reset mid-frame, `reset_n` pulsed low asynchronously between edges: all outputs 0 immediately. `ovf_clr` asserted in the same edge as a new overflow leaves the flag set.
